// File: rtl/rfphoenix_issue_buffer.sv
// ---------------------------------------------------------------------------
// rfphoenix_issue_buffer
//
// Small in-order FIFO between the decoder and the execute pipeline. The head
// entry is shown to the register scoreboard on sb_db. The scoreboard replies
// one cycle later on sb_can_issue. The head is launched into a registered
// issue stage (iss_v/iss_bus) under a valid/ready handshake with execute.
// A flush (rollback / branch miss) empties the buffer and the issue register.
//
// Parameters:
//   DEPTH  number of buffered instructions (power of two, 2..16)
//   AW     pointer width, $clog2(DEPTH)
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   dec_v/dec_bus   decoder instruction in; dec_ready = accepted this cycle
//   sb_db           head entry to the scoreboard (.v = 0 when empty)
//   sb_can_issue    registered scoreboard verdict for last cycle's sb_db
//   will_issue      head issues this cycle (also clears scoreboard target)
//   ex_ready        execute stage can accept
//   iss_v/iss_bus   issue register
//   flush           discard everything buffered and in the issue register
//   count           entries currently held (0..DEPTH)
//
// Optional build macro RFPHOENIX_ISSUE_STATS_EN adds the 32-bit counters
// stat_issued, stat_dep_stall and stat_full.
// ---------------------------------------------------------------------------
package rfPhoenixPkg;
  typedef struct packed {
    logic        v;
    logic [6:0]  opcode;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rt;
    logic [31:0] imm;
  } DecodeBus;
endpackage

module rfphoenix_issue_buffer
  import rfPhoenixPkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_v,
  input  DecodeBus      dec_bus,
  output logic          dec_ready,
  output DecodeBus      sb_db,
  input  logic          sb_can_issue,
  output logic          will_issue,
  input  logic          ex_ready,
  output logic          iss_v,
  output DecodeBus      iss_bus,
  input  logic          flush,
  output logic [AW:0]   count
`ifdef RFPHOENIX_ISSUE_STATS_EN
  ,
  output logic [31:0]   stat_issued,
  output logic [31:0]   stat_dep_stall,
  output logic [31:0]   stat_full
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  DecodeBus          mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              head_settled_reg;
  logic              iss_v_reg;
  DecodeBus          iss_bus_reg;

  logic              not_empty;
  logic              full;
  logic              push;

  assign not_empty = (count_reg != '0);
  assign full      = (count_reg == DEPTH_C);

  // Head is read asynchronously so the scoreboard sees it in the same cycle.
  always_comb begin
    sb_db   = mem[rd_ptr_reg];
    sb_db.v = not_empty;
  end

  // sb_can_issue refers to last cycle's sb_db, so it is only trusted once the
  // head has been on sb_db unchanged for a full cycle (head_settled_reg).
  assign will_issue = not_empty & head_settled_reg & sb_can_issue & ex_ready & ~flush;
  assign dec_ready  = ~full | will_issue;
  assign push       = dec_v & dec_ready & ~flush;

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= dec_bus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      head_settled_reg <= 1'b0;
      iss_v_reg        <= 1'b0;
      iss_bus_reg      <= '0;
    end else if (flush) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      head_settled_reg <= 1'b0;
      iss_v_reg        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (will_issue) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, will_issue})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      // A head that was presented this cycle and not popped is the same head
      // next cycle. A push into an empty buffer creates a fresh, unsettled head.
      head_settled_reg <= not_empty & ~will_issue;
      if (will_issue) begin
        iss_bus_reg <= sb_db;
        iss_v_reg   <= 1'b1;
      end else if (ex_ready) begin
        iss_v_reg   <= 1'b0;
      end
    end
  end

  assign count   = count_reg;
  assign iss_v   = iss_v_reg;
  assign iss_bus = iss_bus_reg;

`ifdef RFPHOENIX_ISSUE_STATS_EN
  logic [31:0] stat_issued_reg;
  logic [31:0] stat_dep_stall_reg;
  logic [31:0] stat_full_reg;

  // Counters ignore flush; they only clear on reset and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_reg    <= '0;
      stat_dep_stall_reg <= '0;
      stat_full_reg      <= '0;
    end else begin
      if (will_issue) begin
        stat_issued_reg <= stat_issued_reg + 32'd1;
      end
      if (not_empty & head_settled_reg & ex_ready & ~sb_can_issue) begin
        stat_dep_stall_reg <= stat_dep_stall_reg + 32'd1;
      end
      if (full & dec_v & ~dec_ready) begin
        stat_full_reg <= stat_full_reg + 32'd1;
      end
    end
  end

  assign stat_issued    = stat_issued_reg;
  assign stat_dep_stall = stat_dep_stall_reg;
  assign stat_full      = stat_full_reg;
`endif

endmodule

// File: tb/tb_rfphoenix_issue_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for rfphoenix_issue_buffer (DEPTH = 4).
// The reference model is a queue of instructions plus the number of cycles
// the current head has been on display; all expected outputs come from it.
// ---------------------------------------------------------------------------
module tb_rfphoenix_issue_buffer;
  import rfPhoenixPkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_v = 1'b0;
  DecodeBus    dec_bus = '0;
  logic        dec_ready;
  DecodeBus    sb_db;
  logic        sb_can_issue = 1'b0;
  logic        will_issue;
  logic        ex_ready = 1'b1;
  logic        iss_v;
  DecodeBus    iss_bus;
  logic        flush = 1'b0;
  logic [AW:0] count;
`ifdef RFPHOENIX_ISSUE_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_dep_stall;
  logic [31:0] stat_full;
`endif

  always #5 clk = ~clk;

  rfphoenix_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_v        (dec_v),
    .dec_bus      (dec_bus),
    .dec_ready    (dec_ready),
    .sb_db        (sb_db),
    .sb_can_issue (sb_can_issue),
    .will_issue   (will_issue),
    .ex_ready     (ex_ready),
    .iss_v        (iss_v),
    .iss_bus      (iss_bus),
    .flush        (flush),
    .count        (count)
`ifdef RFPHOENIX_ISSUE_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_dep_stall (stat_dep_stall),
    .stat_full      (stat_full)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  DecodeBus    q[$];
  int          head_age;
  logic        m_iss_v;
  DecodeBus    m_iss_bus;
  logic [31:0] m_issued;
  logic [31:0] m_stall;
  logic [31:0] m_full;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    head_age  = 0;
    m_iss_v   = 1'b0;
    m_iss_bus = '0;
    m_issued  = '0;
    m_stall   = '0;
    m_full    = '0;
  endtask

  function automatic DecodeBus rand_bus();
    DecodeBus b;
    b.v      = 1'b1;
    b.opcode = 7'($urandom_range(0, 127));
    b.ra     = 5'($urandom_range(0, 31));
    b.rb     = 5'($urandom_range(0, 31));
    b.rt     = 5'($urandom_range(0, 31));
    b.imm    = $urandom();
    return b;
  endfunction

  // One clock cycle: check DUT against the model mid-cycle, then advance the
  // model with the inputs that were applied during this cycle.
  task automatic tick();
    logic     exp_will;
    logic     exp_ready;
    int       sz;
    DecodeBus b;
    @(negedge clk);
    sz        = q.size();
    exp_will  = (sz != 0) && (head_age >= 1) && sb_can_issue && ex_ready && !flush;
    exp_ready = (sz != DEPTH) || exp_will;
    chk("count",      64'(count),      64'(sz));
    chk("dec_ready",  64'(dec_ready),  64'(exp_ready));
    chk("will_issue", 64'(will_issue), 64'(exp_will));
    chk("sb_v",       64'(sb_db.v),    64'(sz != 0));
    if (sz != 0) chk("sb_db", 64'(sb_db), 64'(q[0]));
    chk("iss_v",      64'(iss_v),      64'(m_iss_v));
    chk("iss_bus",    64'(iss_bus),    64'(m_iss_bus));
`ifdef RFPHOENIX_ISSUE_STATS_EN
    chk("stat_issued",    64'(stat_issued),    64'(m_issued));
    chk("stat_dep_stall", 64'(stat_dep_stall), 64'(m_stall));
    chk("stat_full",      64'(stat_full),      64'(m_full));
`endif
    if (exp_will) m_issued++;
    if ((sz != 0) && (head_age >= 1) && ex_ready && !sb_can_issue) m_stall++;
    if ((sz == DEPTH) && dec_v && !exp_ready) m_full++;
    if (flush) begin
      q.delete();
      head_age = 0;
      m_iss_v  = 1'b0;
    end else begin
      if (exp_will) begin
        m_iss_bus = q.pop_front();
        m_iss_v   = 1'b1;
        head_age  = 0;
      end else begin
        if (ex_ready) m_iss_v = 1'b0;
        if (sz != 0) head_age++;
      end
      if (dec_v && exp_ready) begin
        b   = dec_bus;
        b.v = 1'b1;
        q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_count",     64'(count),      64'(0));
    chk("rst_dec_ready", 64'(dec_ready),  64'(1));
    chk("rst_iss_v",     64'(iss_v),      64'(0));
    chk("rst_iss_bus",   64'(iss_bus),    64'(0));
    chk("rst_sb_v",      64'(sb_db.v),    64'(0));
    chk("rst_will",      64'(will_issue), 64'(0));

    // Single instruction: push, present, issue, register
    sb_can_issue = 1'b1;
    ex_ready     = 1'b1;
    dec_v        = 1'b1;
    dec_bus      = rand_bus();
    dec_bus.rt   = 5'd5;
    tick();
    dec_v = 1'b0;
    tick();
    tick();
    chk("t1_iss_v",  64'(iss_v),      64'(1));
    chk("t1_iss_rt", 64'(iss_bus.rt), 64'(5));
    chk("t1_count",  64'(count),      64'(0));
    tick();

    // Fill with the scoreboard blocking, then drain one every two cycles
    sb_can_issue = 1'b0;
    dec_v        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_bus    = rand_bus();
      dec_bus.rt = 5'(i + 1);
      tick();
    end
    dec_v = 1'b0;
    tick();
    chk("t2_count_full", 64'(count),     64'(4));
    chk("t2_not_ready",  64'(dec_ready), 64'(0));
    sb_can_issue = 1'b1;
    repeat (8) tick();

    // Full buffer with simultaneous push and pop (write pointer wraps)
    sb_can_issue = 1'b0;
    dec_v        = 1'b1;
    repeat (4) begin
      dec_bus = rand_bus();
      tick();
    end
    sb_can_issue = 1'b1;
    repeat (6) begin
      dec_bus = rand_bus();
      tick();
    end
    chk("t3_count_stays", 64'(count), 64'(4));

    // ex_ready low: no issue, issue register held
    dec_v    = 1'b0;
    ex_ready = 1'b0;
    repeat (3) tick();
    ex_ready = 1'b1;
    repeat (3) tick();

    // Flush with three entries held and iss_v set
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    sb_can_issue = 1'b0;
    dec_v        = 1'b1;
    repeat (4) begin
      dec_bus = rand_bus();
      tick();
    end
    dec_v        = 1'b0;
    sb_can_issue = 1'b1;
    tick();
    sb_can_issue = 1'b0;
    chk("t5_pre_count", 64'(count), 64'(3));
    chk("t5_pre_iss_v", 64'(iss_v), 64'(1));
    flush   = 1'b1;
    dec_v   = 1'b1;
    dec_bus = rand_bus();
    tick();
    flush = 1'b0;
    dec_v = 1'b0;
    chk("t5_count", 64'(count),   64'(0));
    chk("t5_iss_v", 64'(iss_v),   64'(0));
    chk("t5_sb_v",  64'(sb_db.v), 64'(0));
    tick();

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      dec_v        = ($urandom_range(0, 3) != 0);
      dec_bus      = rand_bus();
      sb_can_issue = ($urandom_range(0, 3) != 0);
      ex_ready     = ($urandom_range(0, 4) != 0);
      flush        = ($urandom_range(0, 31) == 0);
      if (i == 200) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_count",     64'(count),     64'(0));
        chk("arst_iss_v",     64'(iss_v),     64'(0));
        chk("arst_sb_v",      64'(sb_db.v),   64'(0));
        chk("arst_dec_ready", 64'(dec_ready), 64'(1));
`ifdef RFPHOENIX_ISSUE_STATS_EN
        chk("arst_stat_issued", 64'(stat_issued), 64'(0));
`endif
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
      end
      tick();
    end

    dec_v = 1'b0;
    flush = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
